// File: rtl/spi_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_slave
// Description : Oversampled mode-0 SPI responder serving an 8-bit register
//               bank, fully synchronous to mclk.
// Revision    : 1.0
// ============================================================================
module spi_reg_slave #(
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RESET_VAL   = 8'h00
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [6:0] loc_addr,
    output logic [7:0] loc_rdata,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_strobe,
    output logic       frame_err,
    output logic       busy
);

    localparam int         c_aw       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [7:0] c_num_regs = 8'(NUM_REGS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2,
        DONE   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;

    logic w_sclk;
    logic w_cs;
    logic w_mosi;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_rise;
    logic w_cs_fall;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [6:0] r_shift;
    logic       r_rd;
    logic [6:0] r_addr;
    logic       r_addr_ok;
    logic [7:0] r_shadow;
    logic [7:0] regs [NUM_REGS];

    logic [7:0] w_shift_next;
    logic       w_hdr_ok;

    // cs chain resets to the deselected level so no false edge follows reset
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_prev <= w_sclk;
            r_cs_prev   <= w_cs;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk & r_sclk_prev;
    assign w_cs_rise   = w_cs & ~r_cs_prev;
    assign w_cs_fall   = ~w_cs & r_cs_prev;

    assign w_shift_next = {r_shift, w_mosi};
    assign w_hdr_ok     = {1'b0, w_shift_next[6:0]} < c_num_regs;

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_shift   <= 7'd0;
            r_rd      <= 1'b0;
            r_addr    <= 7'd0;
            r_addr_ok <= 1'b0;
            r_shadow  <= 8'h00;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            wr_addr   <= 7'd0;
            wr_data   <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    miso    <= 1'b0;
                    miso_oe <= 1'b0;
                    busy    <= 1'b0;
                    if (w_cs_fall) begin
                        r_state <= HEADER;
                        r_cnt   <= 4'd0;
                        busy    <= 1'b1;
                        miso_oe <= 1'b1;
                    end
                end
                HEADER: begin
                    // cs takes priority over any sclk edge seen in the same cycle
                    if (w_cs_rise) begin
                        r_state   <= IDLE;
                        r_cnt     <= 4'd0;
                        busy      <= 1'b0;
                        miso_oe   <= 1'b0;
                        miso      <= 1'b0;
                        frame_err <= 1'b1;
                    end else if (w_sclk_rise) begin
                        r_shift <= w_shift_next[6:0];
                        r_cnt   <= r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            r_state   <= DATA;
                            r_rd      <= w_shift_next[7];
                            r_addr    <= w_shift_next[6:0];
                            r_addr_ok <= w_hdr_ok;
                            if (w_shift_next[7]) begin
                                if (w_hdr_ok) begin
                                    r_shadow  <= regs[w_shift_next[c_aw-1:0]];
                                    rd_strobe <= 1'b1;
                                end else begin
                                    r_shadow  <= 8'h00;
                                    frame_err <= 1'b1;
                                end
                            end
                        end
                    end
                end
                DATA: begin
                    if (w_cs_rise) begin
                        r_state   <= IDLE;
                        r_cnt     <= 4'd0;
                        busy      <= 1'b0;
                        miso_oe   <= 1'b0;
                        miso      <= 1'b0;
                        frame_err <= 1'b1;
                    end else if (w_sclk_rise) begin
                        r_shift <= w_shift_next[6:0];
                        r_cnt   <= r_cnt + 4'd1;
                        if (r_cnt == 4'd15) begin
                            r_state <= DONE;
                            miso    <= 1'b0;
                            if (!r_rd) begin
                                if (r_addr_ok) begin
                                    regs[r_addr[c_aw-1:0]] <= w_shift_next;
                                    wr_strobe <= 1'b1;
                                    wr_addr   <= r_addr;
                                    wr_data   <= w_shift_next;
                                end else begin
                                    frame_err <= 1'b1;
                                end
                            end
                        end
                    end else if (w_sclk_fall && r_rd) begin
                        miso     <= r_shadow[7];
                        r_shadow <= {r_shadow[6:0], 1'b0};
                    end
                end
                DONE: begin
                    miso <= 1'b0;
                    if (w_cs_rise) begin
                        r_state <= IDLE;
                        r_cnt   <= 4'd0;
                        busy    <= 1'b0;
                        miso_oe <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        loc_rdata = 8'h00;
        if ({1'b0, loc_addr} < c_num_regs) begin
            loc_rdata = regs[loc_addr[c_aw-1:0]];
        end
    end

endmodule
`default_nettype wire
